// File: rtl/cpu_test_monitor_if.sv
// Bus bundle between a CPU core bench and cpu_test_monitor.
// Carries the CPU address/data bus, the bench preload port, the run status
// and the fetch-history tap.
//   master : CPU/bench side (drives bus and preload, observes status)
//   slave  : monitor side (drives CLK_en, Data_out, status, hist_adr)
interface cpu_test_monitor_if #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned HIST_SEL_W = 3
);
   logic                  CLK_en;
   logic [ADDR_W-1:0]     Address_bus;
   logic                  RnW;
   logic                  SYNC;
   logic [DATA_W-1:0]     Data_in;
   logic [DATA_W-1:0]     Data_out;
   logic                  load_we;
   logic [ADDR_W-1:0]     load_adr;
   logic [DATA_W-1:0]     load_data;
   logic                  DONE;
   logic                  PASS;
   logic                  TRAP;
   logic                  TIMEOUT;
   logic [ADDR_W-1:0]     TRAP_ADR;
   logic [31:0]           cycle_count;
   logic [HIST_SEL_W-1:0] hist_sel;
   logic [ADDR_W-1:0]     hist_adr;

   modport master (
      output Address_bus, RnW, SYNC, Data_in, load_we, load_adr, load_data, hist_sel,
      input  CLK_en, Data_out, DONE, PASS, TRAP, TIMEOUT, TRAP_ADR, cycle_count, hist_adr
   );

   modport slave (
      input  Address_bus, RnW, SYNC, Data_in, load_we, load_adr, load_data, hist_sel,
      output CLK_en, Data_out, DONE, PASS, TRAP, TIMEOUT, TRAP_ADR, cycle_count, hist_adr
   );
endinterface

// File: rtl/cpu_test_monitor.sv
// Bus-side harness for CPU core benches: flat RAM model, clock-enable divider
// and a run monitor reporting pass (stop-address write), trap (SYNC stuck on
// one address) or timeout (CLK_en budget exhausted).
// Ports:
//   CLK, nRESET : system clock, asynchronous active-low reset
//   bus (slave) : CPU bus (Address_bus, RnW, SYNC, Data_in -> Data_out, CLK_en),
//                 preload (load_we/adr/data), sticky status (DONE, PASS, TRAP,
//                 TIMEOUT, TRAP_ADR, cycle_count), history tap (hist_sel -> hist_adr)
// Optional: define CPU_TEST_MONITOR_TRACE_EN to build the HIST_DEPTH-entry
// fetch-history buffer; otherwise hist_adr is tied to 0.
module cpu_test_monitor #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned CLKDIV_LOG2 = 4,
   parameter int unsigned STOP_ADR    = 32'h0000_FFFC,
   parameter int unsigned TIME_LIMIT  = 20000000,
   parameter int unsigned TRAP_REPEAT = 1,
   parameter int unsigned HIST_DEPTH  = 8
) (
   input logic             CLK,
   input logic             nRESET,
   cpu_test_monitor_if.slave bus
);
   localparam int unsigned       MEM_DEPTH = 2 ** ADDR_W;
   localparam int unsigned       HSEL_W    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] STOP_A    = ADDR_W'(STOP_ADR);
   localparam logic [31:0]       LIMIT     = 32'(TIME_LIMIT);
   localparam logic [31:0]       REPEAT    = 32'(TRAP_REPEAT);

   typedef enum logic [1:0] {RUN, PASS_ST, TRAP_ST, TIMEOUT_ST} state_t;

   state_t               state_q, state_d;
   logic [CLKDIV_LOG2-1:0] div_q;
   logic [DATA_W-1:0]    mem [MEM_DEPTH];
   logic [DATA_W-1:0]    rd_q;
   logic [ADDR_W-1:0]    last_q;
   logic                 last_vld_q;
   logic [ADDR_W-1:0]    trap_adr_q, trap_adr_d;
   logic [31:0]          rep_q, rep_d;
   logic [31:0]          cnt_q, cnt_d;
   logic                 cpu_wr, stop_wr, fetch;

   assign bus.CLK_en = &div_q;
   assign cpu_wr     = !bus.RnW && !bus.load_we;
   assign stop_wr    = cpu_wr && (bus.Address_bus == STOP_A);
   assign fetch      = bus.CLK_en && bus.SYNC && (state_q == RUN);

   // Free-running divider; CLK_en decodes its all-ones state.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) div_q <= '0;
      else         div_q <= div_q + 1'b1;
   end

   // RAM array is not reset so a program image survives nRESET; preload wins.
   always_ff @(posedge CLK) begin
      if (bus.load_we)               mem[bus.load_adr]    <= bus.load_data;
      else if (cpu_wr && !stop_wr)   mem[bus.Address_bus] <= bus.Data_in;
   end

   // Registered read data, one CLK latency regardless of CLK_en.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET)      rd_q <= '0;
      else if (bus.RnW) rd_q <= mem[bus.Address_bus];
   end

   // State and monitor registers.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q    <= RUN;
         rep_q      <= '0;
         cnt_q      <= '0;
         trap_adr_q <= '0;
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rep_q      <= rep_d;
         cnt_q      <= cnt_d;
         trap_adr_q <= trap_adr_d;
         if (fetch) begin
            last_q     <= bus.Address_bus;
            last_vld_q <= 1'b1;
         end
      end
   end

   // Next state: pass beats trap beats timeout when they land together.
   always_comb begin
      state_d    = state_q;
      rep_d      = rep_q;
      cnt_d      = cnt_q;
      trap_adr_d = trap_adr_q;
      if (state_q == RUN) begin
         if (bus.CLK_en && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
         if (fetch) begin
            if (last_vld_q && (bus.Address_bus == last_q))
               rep_d = (rep_q != '1) ? rep_q + 32'd1 : rep_q;
            else
               rep_d = '0;
         end
         if (stop_wr) begin
            state_d = PASS_ST;
         end else if (fetch && (rep_d == REPEAT)) begin
            state_d    = TRAP_ST;
            trap_adr_d = bus.Address_bus;
         end else if (bus.CLK_en && (cnt_d == LIMIT)) begin
            state_d = TIMEOUT_ST;
         end
      end
   end

   assign bus.Data_out    = rd_q;
   assign bus.DONE        = (state_q != RUN);
   assign bus.PASS        = (state_q == PASS_ST);
   assign bus.TRAP        = (state_q == TRAP_ST);
   assign bus.TIMEOUT     = (state_q == TIMEOUT_ST);
   assign bus.TRAP_ADR    = trap_adr_q;
   assign bus.cycle_count = cnt_q;

`ifdef CPU_TEST_MONITOR_TRACE_EN
   logic [ADDR_W-1:0]     hist_mem [HIST_DEPTH];
   logic [HIST_DEPTH-1:0] hist_vld_q;
   logic [HSEL_W-1:0]     hptr_q, hidx;
   logic [ADDR_W-1:0]     hist_q;

   // hptr_q points at the next slot, so newest is hptr_q-1.
   assign hidx = hptr_q - HSEL_W'(1) - bus.hist_sel;

   always_ff @(posedge CLK) begin
      if (fetch) hist_mem[hptr_q] <= bus.Address_bus;
   end

   // Pointer, valid bits and registered selected entry; stops with the FSM.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         hptr_q     <= '0;
         hist_vld_q <= '0;
         hist_q     <= '0;
      end else begin
         if (fetch) begin
            hptr_q             <= hptr_q + HSEL_W'(1);
            hist_vld_q[hptr_q] <= 1'b1;
         end
         hist_q <= hist_vld_q[hidx] ? hist_mem[hidx] : '0;
      end
   end

   assign bus.hist_adr = hist_q;
`else
   logic [HSEL_W-1:0] unused_hist_sel;
   assign unused_hist_sel = bus.hist_sel;
   assign bus.hist_adr    = '0;
`endif
endmodule

// File: tb/tb_cpu_test_monitor.sv
// Directed bench for cpu_test_monitor (TIME_LIMIT shortened to 100).
module tb_cpu_test_monitor;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   logic CLK;
   logic nRESET;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   cpu_test_monitor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HIST_SEL_W(3)) bus ();

   cpu_test_monitor #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLKDIV_LOG2(4), .STOP_ADR(32'h0000_FFFC),
      .TIME_LIMIT(100), .TRAP_REPEAT(1), .HIST_DEPTH(8)
   ) dut (
      .CLK(CLK),
      .nRESET(nRESET),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic idle_bus();
      bus.Address_bus = '0;
      bus.RnW         = 1'b1;
      bus.SYNC        = 1'b0;
      bus.Data_in     = '0;
      bus.load_we     = 1'b0;
      bus.load_adr    = '0;
      bus.load_data   = '0;
      bus.hist_sel    = '0;
   endtask

   task automatic do_reset();
      idle_bus();
      nRESET = 1'b0;
      tick(2);
      @(negedge CLK);
      nRESET = 1'b1;
   endtask

   // Wait for CLK_en, then present a fetch for exactly the consuming edge.
   task automatic do_sync(input logic [ADDR_W-1:0] adr, input logic rnw);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (bus.CLK_en) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total_cnt++;
         $display("FAIL wait_clk_en: CLK_en not seen in 40 cycles, required within 16");
      end
      bus.Address_bus = adr;
      bus.SYNC        = 1'b1;
      bus.RnW         = rnw;
      bus.Data_in     = 8'h55;
      tick(1);
      bus.SYNC = 1'b0;
      bus.RnW  = 1'b1;
   endtask

   task automatic cpu_write(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] d);
      bus.Address_bus = adr;
      bus.Data_in     = d;
      bus.RnW         = 1'b0;
      tick(1);
      bus.RnW = 1'b1;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] d);
      bus.load_adr  = adr;
      bus.load_data = d;
      bus.load_we   = 1'b1;
      tick(1);
      bus.load_we = 1'b0;
   endtask

   task automatic read(input logic [ADDR_W-1:0] adr, output logic [DATA_W-1:0] d);
      bus.Address_bus = adr;
      bus.RnW         = 1'b1;
      tick(1);
      d = bus.Data_out;
   endtask

   function automatic logic [3:0] flags();
      return {bus.DONE, bus.PASS, bus.TRAP, bus.TIMEOUT};
   endfunction

   task automatic test_reset();
      idle_bus();
      nRESET = 1'b0;
      tick(1);
      preload(16'h0201, 8'h3C);
      total_cnt++;
      if ({bus.CLK_en, flags()} !== 5'b0) $display("FAIL reset_flags: got %b, required 00000", {bus.CLK_en, flags()});
      else pass_cnt++;
      total_cnt++;
      if (bus.cycle_count !== 32'd0) $display("FAIL reset_count: got %0d, required 0", bus.cycle_count);
      else pass_cnt++;
      total_cnt++;
      if (bus.TRAP_ADR !== 16'h0) $display("FAIL reset_trap_adr: got %h, required 0000", bus.TRAP_ADR);
      else pass_cnt++;
      total_cnt++;
      if (bus.Data_out !== 8'h00) $display("FAIL reset_data_out: got %h, required 00", bus.Data_out);
      else pass_cnt++;
   endtask

   task automatic test_divider();
      do_reset();
      for (int k = 1; k <= 48; k++) begin
         tick(1);
         total_cnt++;
         if (bus.CLK_en !== ((k % 16) == 15)) $display("FAIL divider_c%0d: got %b, required %b", k, bus.CLK_en, ((k % 16) == 15));
         else pass_cnt++;
      end
      total_cnt++;
      if (bus.cycle_count !== 32'd3) $display("FAIL divider_count: got %0d, required 3", bus.cycle_count);
      else pass_cnt++;
   endtask

   task automatic test_read_stop();
      logic [DATA_W-1:0] d;
      do_reset();
      preload(16'h0200, 8'hA9);
      preload(16'hFFFC, 8'h77);
      read(16'h0201, d);
      total_cnt++;
      if (d !== 8'h3C) $display("FAIL preload_in_reset: got %h, required 3C", d);
      else pass_cnt++;
      read(16'h0200, d);
      total_cnt++;
      if (d !== 8'hA9) $display("FAIL read_latency: got %h, required A9", d);
      else pass_cnt++;
      cpu_write(16'hFFFC, 8'h55);
      total_cnt++;
      if (flags() !== 4'b1100) $display("FAIL stop_pass: got %b, required 1100", flags());
      else pass_cnt++;
      read(16'hFFFC, d);
      total_cnt++;
      if (d !== 8'h77) $display("FAIL stop_no_write: got %h, required 77", d);
      else pass_cnt++;
      cpu_write(16'h0300, 8'h5A);
      read(16'h0300, d);
      total_cnt++;
      if (d !== 8'h5A) $display("FAIL ram_after_done: got %h, required 5A", d);
      else pass_cnt++;
   endtask

   task automatic test_trap();
      do_reset();
      do_sync(16'h3469, 1'b1);
      total_cnt++;
      if (flags() !== 4'b0000) $display("FAIL first_sync_no_trap: got %b, required 0000", flags());
      else pass_cnt++;
      do_sync(16'h3469, 1'b1);
      total_cnt++;
      if (flags() !== 4'b1010) $display("FAIL trap_flag: got %b, required 1010", flags());
      else pass_cnt++;
      total_cnt++;
      if (bus.TRAP_ADR !== 16'h3469) $display("FAIL trap_adr: got %h, required 3469", bus.TRAP_ADR);
      else pass_cnt++;
      tick(40);
      total_cnt++;
      if (bus.cycle_count !== 32'd2) $display("FAIL trap_count_frozen: got %0d, required 2", bus.cycle_count);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 99; i++) do_sync(16'h1000 + 16'(i), 1'b1);
      total_cnt++;
      if (flags() !== 4'b0000 || bus.cycle_count !== 32'd99)
         $display("FAIL timeout_before: got flags %b count %0d, required 0000 count 99", flags(), bus.cycle_count);
      else pass_cnt++;
      do_sync(16'h1063, 1'b1);
      total_cnt++;
      if (flags() !== 4'b1001 || bus.cycle_count !== 32'd100)
         $display("FAIL timeout_at_limit: got flags %b count %0d, required 1001 count 100", flags(), bus.cycle_count);
      else pass_cnt++;
      tick(40);
      cpu_write(16'hFFFC, 8'h55);
      total_cnt++;
      if (flags() !== 4'b1001 || bus.cycle_count !== 32'd100)
         $display("FAIL timeout_sticky: got flags %b count %0d, required 1001 count 100", flags(), bus.cycle_count);
      else pass_cnt++;
   endtask

   task automatic test_collision();
      logic [DATA_W-1:0] d;
      do_reset();
      bus.load_adr    = 16'h0010;
      bus.load_data   = 8'h11;
      bus.load_we     = 1'b1;
      bus.Address_bus = 16'h0010;
      bus.Data_in     = 8'h22;
      bus.RnW         = 1'b0;
      tick(1);
      bus.load_we = 1'b0;
      bus.RnW     = 1'b1;
      read(16'h0010, d);
      total_cnt++;
      if (d !== 8'h11) $display("FAIL preload_collision: got %h, required 11", d);
      else pass_cnt++;
      bus.load_adr    = 16'h0011;
      bus.load_data   = 8'h66;
      bus.load_we     = 1'b1;
      bus.Address_bus = 16'hFFFC;
      bus.RnW         = 1'b0;
      tick(1);
      bus.load_we = 1'b0;
      bus.RnW     = 1'b1;
      total_cnt++;
      if (flags() !== 4'b0000) $display("FAIL stop_masked_by_load: got %b, required 0000", flags());
      else pass_cnt++;
      read(16'h0011, d);
      total_cnt++;
      if (d !== 8'h66) $display("FAIL load_during_stop: got %h, required 66", d);
      else pass_cnt++;
   endtask

   task automatic test_priority();
      do_reset();
      do_sync(16'hFFFC, 1'b1);
      do_sync(16'hFFFC, 1'b0);
      total_cnt++;
      if (flags() !== 4'b1100) $display("FAIL priority_pass: got %b, required 1100", flags());
      else pass_cnt++;
      total_cnt++;
      if (bus.TRAP_ADR !== 16'h0) $display("FAIL priority_trap_adr: got %h, required 0000", bus.TRAP_ADR);
      else pass_cnt++;
   endtask

   task automatic test_reset_midrun();
      logic [DATA_W-1:0] d;
      do_reset();
      do_sync(16'h4000, 1'b1);
      do_sync(16'h4000, 1'b1);
      do_reset();
      total_cnt++;
      if (flags() !== 4'b0000 || bus.cycle_count !== 32'd0 || bus.TRAP_ADR !== 16'h0)
         $display("FAIL midrun_reset: got flags %b count %0d adr %h, required 0000 0 0000", flags(), bus.cycle_count, bus.TRAP_ADR);
      else pass_cnt++;
      read(16'h0200, d);
      total_cnt++;
      if (d !== 8'hA9) $display("FAIL ram_kept: got %h, required A9", d);
      else pass_cnt++;
      do_sync(16'h4000, 1'b1);
      total_cnt++;
      if (flags() !== 4'b0000) $display("FAIL last_cleared: got %b, required 0000", flags());
      else pass_cnt++;
   endtask

   task automatic test_trace();
      logic [ADDR_W-1:0] exp [4];
`ifdef CPU_TEST_MONITOR_TRACE_EN
      exp[0] = 16'h0A02; exp[1] = 16'h0A01; exp[2] = 16'h0A00; exp[3] = 16'h0000;
`else
      exp[0] = 16'h0000; exp[1] = 16'h0000; exp[2] = 16'h0000; exp[3] = 16'h0000;
`endif
      do_reset();
      do_sync(16'h0A00, 1'b1);
      do_sync(16'h0A01, 1'b1);
      do_sync(16'h0A02, 1'b1);
      for (int s = 0; s < 4; s++) begin
         bus.hist_sel = 3'(s);
         tick(2);
         total_cnt++;
         if (bus.hist_adr !== exp[s]) $display("FAIL hist_sel%0d: got %h, required %h", s, bus.hist_adr, exp[s]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_divider();
      test_read_stop();
      test_trap();
      test_timeout();
      test_collision();
      test_priority();
      test_reset_midrun();
      test_trace();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/cpu_test_monitor.md
Name: cpu_test_monitor

Overview:
Parametrised bus-side harness for CPU cores: a flat RAM model, a clock-enable divider, and a run monitor that reports pass, trap or timeout. Sits on the CPU address/data bus in core-level benches. The CPU side sees `CLK_en` and registered read data. The bench side gets a preload port and sticky status flags. It generalises address and data width, divider ratio, stop address, time limit and trap depth, and adds structured status plus an optional fetch-history trace.

Parameters:
- ADDR_W, 16, address bus width; the RAM holds exactly 2**ADDR_W words.
- DATA_W, 8, data word width.
- CLKDIV_LOG2, 4, `CLK_en` period is 2**CLKDIV_LOG2 `CLK` cycles.
- STOP_ADR, 16'hFFFC, a CPU write to this address signals success.
- TIME_LIMIT, 20000000, number of `CLK_en` pulses allowed before timeout.
- TRAP_REPEAT, 1, number of consecutive identical SYNC addresses, after the first, that flag a trap.
- HIST_DEPTH, 8, fetch-history entries (power of two); used only with the trace feature.

Ports:
- CLK  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- CLK_en  out  1  CPU clock enable, one `CLK` wide
- Address_bus  in  ADDR_W  CPU address
- RnW  in  1  1 = read, 0 = write
- SYNC  in  1  CPU opcode-fetch indicator
- Data_in  in  DATA_W  CPU write data
- Data_out  out  DATA_W  registered read data
- load_we  in  1  bench preload write strobe
- load_adr  in  ADDR_W  preload address
- load_data  in  DATA_W  preload data
- DONE  out  1  sticky, any terminal state reached
- PASS  out  1  sticky, stop address written
- TRAP  out  1  sticky, trap detected
- TIMEOUT  out  1  sticky, time limit expired
- TRAP_ADR  out  ADDR_W  address that caused the trap
- cycle_count  out  32  `CLK_en` pulses since reset, saturating
- hist_sel  in  log2(HIST_DEPTH)  history index; 0 = newest
- hist_adr  out  ADDR_W  selected history entry

Behaviour:
- Reset (nRESET low, async): divider = 0; `CLK_en`, DONE, PASS, TRAP, TIMEOUT = 0; `TRAP_ADR` = 0; `cycle_count` = 0; `Data_out` = 0; repeat counter = 0; last-address-valid = 0; history pointer = 0. RAM contents are not reset.
- Divider: a CLKDIV_LOG2-bit counter increments every `CLK`. `CLK_en` = counter all-ones (combinational from the registered counter). First pulse occurs on cycle 2**CLKDIV_LOG2 - 1 after reset release.
- Read: each `CLK` with `RnW` = 1, `Data_out` <= mem[`Address_bus`]. One-cycle latency, independent of `CLK_en`.
- Write: each `CLK` with `RnW` = 0 and `load_we` = 0:
  - `Address_bus` == STOP_ADR: no RAM write; PASS is set if not DONE.
  - Otherwise mem[`Address_bus`] <= `Data_in`.
- Preload: `load_we` = 1 writes `load_data` to mem[`load_adr`] and suppresses any CPU write in that cycle. Valid in any state, including while in reset.
- State machine RUN -> {PASS_ST, TRAP_ST, TIMEOUT_ST}:
  - All three outcome states are terminal until nRESET.
  - DONE = state != RUN.
  - `cycle_count` freezes when DONE.
  - The RAM stays functional after DONE.
- Trap detection, on `CLK_en` & `SYNC` in RUN:
  - If last-address-valid and `Address_bus` == last: repeat count increments; otherwise it clears to 0.
  - last <= `Address_bus`; last-address-valid <= 1.
  - When the repeat count reaches TRAP_REPEAT: go to TRAP_ST and capture `TRAP_ADR`.
  - The first SYNC after reset never traps.
- Timeout: in RUN, each `CLK_en` increments `cycle_count`. When `cycle_count` reaches TIME_LIMIT, go to TIMEOUT_ST.
- Simultaneous events in one cycle: PASS > TRAP > TIMEOUT. Exactly one status flag is ever set.
- Reset mid-run clears all status; RAM keeps the program image.
- Width: STOP_ADR is truncated or zero-extended to ADDR_W.

Optional Feature:
- Macro: `CPU_TEST_MONITOR_TRACE_EN`.
- Defined: a HIST_DEPTH circular buffer of SYNC addresses.
  - Written on every `CLK_en` & `SYNC` while in RUN.
  - `hist_adr` = entry `hist_sel` back from the newest; unwritten entries read 0.
  - Frozen when DONE, for post-mortem inspection.
- Undefined: no buffer; `hist_adr` is tied to 0 and `hist_sel` is ignored.

Test Plan:
- Divider: CLKDIV_LOG2=4, release reset -> `CLK_en` high on `CLK` cycles 15, 31, 47…, one cycle wide each.
- Read latency and stop write:
  - Preload mem[16'h0200]=8'hA9, drive read of 16'h0200 -> `Data_out`=8'hA9 one `CLK` later.
  - CPU write 8'h55 to 16'hFFFC -> PASS=1, DONE=1, mem[16'hFFFC] unchanged.
- Trap: SYNC at 16'h3469 on two consecutive `CLK_en` with TRAP_REPEAT=1 -> TRAP=1, `TRAP_ADR`=16'h3469, `cycle_count` frozen.
- Timeout: TIME_LIMIT=100, distinct SYNC addresses -> TIMEOUT=1 exactly at `cycle_count`=100. A later write to STOP_ADR leaves PASS=0.
- Preload collision: `load_we`=1 to 16'h0010 with data 8'h11 while the CPU writes 8'h22 to the same address -> mem=8'h11.
- Priority and reset: stop write coincides with a trapping SYNC -> only PASS set. Pulse nRESET mid-run -> all flags 0 and RAM image intact. With TRACE_EN, `hist_sel`=0 returns the last SYNC address.
